// File: rtl/mem_readback.sv
// mem_readback -- reads a block of words from a synchronous memory once the
// processor reports HALTED, and presents each word on a valid/ready output.
//
// State table
//   state       | meaning
//   S_IDLE      | waiting for start; zero-count start pulses done here
//   S_WAIT_HALT | transfer accepted, waiting for halted=1
//   S_READ      | one-cycle memory read strobe at the address counter
//   S_WAIT_DATA | read data arrives; captured into the output register
//   S_OUTPUT    | word held on out_* until the valid/ready handshake
//
// Ports
//   clk1, rst        : clock, synchronous active-high reset
//   start            : one-cycle readback request (honoured only in S_IDLE)
//   halted           : processor HALTED flag, gates the first read only
//   base_addr        : first word address, sampled on accepted start
//   word_count       : words to read (0 .. 2^ADDR_W), sampled on accepted start
//   mem_rd_en/addr   : memory read port; mem_rd_data valid one cycle later
//   out_valid/ready  : output handshake for out_data/out_addr
//   busy             : high whenever not in S_IDLE
//   done             : one-cycle pulse at the end of a readback
module mem_readback #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              halted,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HALT,
    S_READ,
    S_WAIT_DATA,
    S_OUTPUT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                done_q, done_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_WAIT_HALT;
          end
        end
      end
      S_WAIT_HALT: begin
        if (halted) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        out_data_d  = mem_rd_data;
        out_addr_d  = addr_q;
        out_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - 1'b1;
          // Address counter wraps naturally at 2^ADDR_W.
          addr_d      = addr_q + 1'b1;
          if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en   = (state_q == S_READ);
  assign mem_rd_addr = addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback with a synchronous memory model.
module tb_mem_readback;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst, start, halted, out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy, done;

  logic [DW-1:0] mem [0:1023];

  mem_readback #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1(clk1), .rst(rst), .start(start), .halted(halted),
    .base_addr(base_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  // Data only valid the cycle after a strobe; otherwise a poison value.
  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= 32'hDEAD_BEEF;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  int            q_cyc[$];
  int            n_done, n_rd, first_valid;

  // Pulse start, then observe for a fixed number of cycles; c counts edges since start.
  task automatic run(input int base, input int cnt, input int cycles);
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    n_done = 0; n_rd = 0; first_valid = -1;
    base_addr  = base[AW-1:0];
    word_count = cnt[AW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) n_done++;
      if (mem_rd_en) n_rd++;
      if (out_valid && out_ready) begin
        q_addr.push_back(out_addr);
        q_data.push_back(out_data);
        q_cyc.push_back(c);
      end
      tick();
    end
  endtask

  int e_rd, e_busy, e_stable;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i * 3;
    mem[120] = 32'd85;
    mem[121] = 32'd130;

    rst = 1'b1; start = 1'b0; halted = 1'b0; out_ready = 1'b0;
    base_addr = '0; word_count = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", out_addr, 0);
    rst = 1'b0;
    tick();

    // Two words from 120, halted already set, consumer always ready.
    halted = 1'b1; out_ready = 1'b1;
    run(120, 2, 14);
    chk("b_nwords", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      chk("b_addr0", q_addr[0], 120);
      chk("b_data0", q_data[0], 85);
      chk("b_addr1", q_addr[1], 121);
      chk("b_data1", q_data[1], 130);
      chk("b_thru", q_cyc[1] - q_cyc[0], 3);
    end
    chk("b_latency", first_valid, 4);
    chk("b_done", n_done, 1);
    chk("b_nrd", n_rd, 2);

    // Wrap at top of address space.
    run(1023, 3, 16);
    chk("w_nwords", q_addr.size(), 3);
    if (q_addr.size() == 3) begin
      chk("w_addr0", q_addr[0], 1023);
      chk("w_addr1", q_addr[1], 0);
      chk("w_addr2", q_addr[2], 1);
      chk("w_data1", q_data[1], 32'h1000_0000);
    end
    chk("w_done", n_done, 1);

    // Zero-count start.
    base_addr = 10'd50; word_count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_rd_en", mem_rd_en, 0);
    tick();
    chk("z_done_clr", done, 0);
    chk("z_busy2", busy, 0);

    // Halted low for 20 cycles, then backpressure and ignored start in OUTPUT.
    halted = 1'b0; out_ready = 1'b0;
    base_addr = 10'd300; word_count = 11'd2; start = 1'b1;
    tick();
    start = 1'b0;
    e_rd = 0; e_busy = 0;
    repeat (20) begin
      if (mem_rd_en) e_rd++;
      if (!busy) e_busy++;
      tick();
    end
    chk("h_rd_en_low", e_rd, 0);
    chk("h_busy_high", e_busy, 0);
    halted = 1'b1;
    tick(); tick();
    chk("h_valid_early", out_valid, 0);
    tick();
    chk("h_valid", out_valid, 1);
    chk("h_addr", out_addr, 300);
    chk("h_data", out_data, mem[300]);
    hold_data = out_data; hold_addr = out_addr;
    halted = 1'b0;
    start = 1'b1; base_addr = 10'd7; word_count = 11'd5;
    e_rd = 0; e_stable = 0;
    repeat (5) begin
      tick();
      if (mem_rd_en) e_rd++;
      if (!out_valid || out_data !== hold_data || out_addr !== hold_addr) e_stable++;
    end
    chk("s_stable", e_stable, 0);
    chk("s_no_rd", e_rd, 0);
    start = 1'b0; out_ready = 1'b1;
    tick();
    chk("s_valid_clr", out_valid, 0);
    chk("s_rd_en", mem_rd_en, 1);
    chk("s_rd_addr", mem_rd_addr, 301);
    tick(); tick();
    chk("s_valid2", out_valid, 1);
    chk("s_addr2", out_addr, 301);
    chk("s_data2", out_data, mem[301]);
    tick();
    chk("s_done", done, 1);
    chk("s_busy_end", busy, 0);
    tick();
    chk("s_done_clr", done, 0);

    // Reset while word 2 of 4 is held.
    halted = 1'b1; out_ready = 1'b1;
    base_addr = 10'd10; word_count = 11'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    out_ready = 1'b0;
    tick();
    chk("r_word2_valid", out_valid, 1);
    chk("r_word2_addr", out_addr, 11);
    rst = 1'b1;
    tick();
    chk("r_valid", out_valid, 0);
    chk("r_done", done, 0);
    chk("r_busy", busy, 0);
    chk("r_rd_en", mem_rd_en, 0);
    chk("r_rd_addr", mem_rd_addr, 0);
    chk("r_data", out_data, 0);
    chk("r_addr", out_addr, 0);
    rst = 1'b0; out_ready = 1'b1;
    n_done = 0;
    repeat (4) begin
      if (done || busy) n_done++;
      tick();
    end
    chk("r_quiet", n_done, 0);
    run(40, 1, 8);
    chk("r2_nwords", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      chk("r2_addr", q_addr[0], 40);
      chk("r2_data", q_data[0], mem[40]);
    end
    chk("r2_done", n_done, 1);

    // Full address range starting mid-space.
    run(512, 1024, 3 * 1024 + 8);
    chk("f_nwords", q_addr.size(), 1024);
    e_stable = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      if (q_addr[i] !== 10'((512 + i) % 1024)) e_stable++;
      if (q_data[i] !== mem[(512 + i) % 1024]) e_stable++;
    end
    chk("f_seq", e_stable, 0);
    chk("f_nrd", n_rd, 1024);
    chk("f_done", n_done, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
